// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: default data width and operation encodings.
package pipelined_adder_pkg;

  localparam int DATA_BITS = 64;

  typedef enum logic [1:0] {
    ADD_OP_ADD  = 2'b00,
    ADD_OP_SUB  = 2'b01,
    ADD_OP_ADDW = 2'b10,
    ADD_OP_SUBW = 2'b11
  } add_op_e;

  function automatic logic op_is_sub(input logic [1:0] mode);
    return (mode == ADD_OP_SUB) || (mode == ADD_OP_SUBW);
  endfunction

  function automatic logic op_is_word(input logic [1:0] mode);
    return (mode == ADD_OP_ADDW) || (mode == ADD_OP_SUBW);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry-rippled slice of the pipelined adder; purely combinational.
module adder_slice #(
  parameter int SW = 32
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep add/sub pipeline, one slice per stage; latency STAGES cycles.
// A single global advance (!out_valid || out_ready) moves or freezes every stage together.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DATA_BITS,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW    = WIDTH / STAGES;
  localparam int HI    = (WIDTH > 32) ? 32 : WIDTH - 1;
  localparam bit HAS_W = (WIDTH > 32);

  if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0 || WIDTH < 32) begin : g_bad_cfg
    $error("pipelined_adder: unsupported WIDTH/STAGES combination");
  end

  logic              w_advance;
  logic              w_sub;
  logic [WIDTH-1:0]  w_b_eff;
  logic [2:0]        w_prop;
  logic [SW-1:0]     w_sa [STAGES];
  logic [SW-1:0]     w_sb [STAGES];
  logic [SW-1:0]     w_ss [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_co;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_word;
  logic [STAGES-1:0] r_cy;
  logic [2:0]        r_prop [STAGES];
  logic [WIDTH-1:0]  r_a    [STAGES];
  logic [WIDTH-1:0]  r_b    [STAGES];
  logic [WIDTH-1:0]  r_sum  [STAGES];

  logic [WIDTH-1:0]  w_fin;
  logic [WIDTH-1:0]  w_res;
  logic              w_c31_in;
  logic              w_c32;
  logic              w_cmsb_in;
  logic              w_carry;
  logic              w_ovf;

  assign w_sub     = op_is_sub(in_mode);
  assign w_b_eff   = w_sub ? ~in_b : in_b;
  // Propagate bits (a^b') at msb, bit 32 and bit 31 let the last stage recover
  // the carry into/out of those positions from the finished sum alone.
  assign w_prop    = {in_a[WIDTH-1] ^ w_b_eff[WIDTH-1], in_a[HI] ^ w_b_eff[HI], in_a[31] ^ w_b_eff[31]};
  assign out_valid = r_vld[STAGES-1];
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = !rst && w_advance;

  always_comb begin
    w_sa[0]  = in_a[SW-1:0];
    w_sb[0]  = w_b_eff[SW-1:0];
    w_cin[0] = w_sub;
    for (int k = 1; k < STAGES; k++) begin
      w_sa[k]  = r_a[k-1][SW-1:0];
      w_sb[k]  = r_b[k-1][SW-1:0];
      w_cin[k] = r_cy[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SW(SW)) u_slice (
      .i_a    (w_sa[k]),
      .i_b    (w_sb[k]),
      .i_cin  (w_cin[k]),
      .o_sum  (w_ss[k]),
      .o_cout (w_co[k])
    );
  end

  // Operands shift down one slice per stage so each stage always adds bits [SW-1:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_word <= '0;
      r_cy   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_prop[k] <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
      end
    end else if (w_advance) begin
      r_vld[0]  <= in_valid;
      r_word[0] <= op_is_word(in_mode);
      r_cy[0]   <= w_co[0];
      r_prop[0] <= w_prop;
      r_a[0]    <= in_a >> SW;
      r_b[0]    <= w_b_eff >> SW;
      r_sum[0]  <= WIDTH'(w_ss[0]);
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_word[k] <= r_word[k-1];
        r_cy[k]   <= w_co[k];
        r_prop[k] <= r_prop[k-1];
        r_a[k]    <= r_a[k-1] >> SW;
        r_b[k]    <= r_b[k-1] >> SW;
        r_sum[k]  <= r_sum[k-1] | (WIDTH'(w_ss[k]) << (k * SW));
      end
    end
  end

  always_comb begin
    w_fin     = r_sum[STAGES-1];
    w_c31_in  = r_prop[STAGES-1][0] ^ w_fin[31];
    w_c32     = r_prop[STAGES-1][1] ^ w_fin[HI];
    w_cmsb_in = r_prop[STAGES-1][2] ^ w_fin[WIDTH-1];
    w_res     = w_fin;
    w_carry   = r_cy[STAGES-1];
    w_ovf     = r_cy[STAGES-1] ^ w_cmsb_in;
    if (HAS_W && r_word[STAGES-1]) begin
      w_res   = WIDTH'(signed'(w_fin[31:0]));
      w_carry = w_c32;
      w_ovf   = w_c32 ^ w_c31_in;
    end
  end

  assign out_result = out_valid ? w_res : '0;
  assign out_carry  = out_valid && w_carry;
  assign out_ovf    = out_valid && w_ovf;
  assign out_zero   = out_valid && (w_res == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 64-bit/2-stage instance plus 32-bit instances with 1 and 4 stages.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  mode;
    res_t        exp;
  } vec_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  m;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_a, in_b, out_result;
  logic [1:0]  in_mode;
  logic        out_carry, out_ovf, out_zero;

  logic        s_valid;
  logic [31:0] s_a, s_b;
  logic [1:0]  s_mode;
  logic        s_ordy = 1'b1;
  logic [1:0]  s_irdy, s_ovld, s_c, s_v, s_z;
  logic [31:0] s_res [2];

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(64), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_irdy[0]), .in_a(s_a), .in_b(s_b),
    .in_mode(s_mode), .out_valid(s_ovld[0]), .out_ready(s_ordy), .out_result(s_res[0]),
    .out_carry(s_c[0]), .out_ovf(s_v[0]), .out_zero(s_z[0])
  );

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_irdy[1]), .in_a(s_a), .in_b(s_b),
    .in_mode(s_mode), .out_valid(s_ovld[1]), .out_ready(s_ordy), .out_result(s_res[1]),
    .out_carry(s_c[1]), .out_ovf(s_v[1]), .out_zero(s_z[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on n-bit operands, overflow judged by signed range.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] mode, input int w);
    int n;
    logic [65:0] ua, ub, ex, mask, wmask;
    logic signed [65:0] sa, sb, sr, smax, smin;
    res_t o;
    n     = (mode[1] && w > 32) ? 32 : w;
    mask  = (66'd1 << n) - 66'd1;
    wmask = (66'd1 << w) - 66'd1;
    ua    = {2'b00, a} & mask;
    ub    = {2'b00, b} & mask;
    sa    = $signed(ua);
    sb    = $signed(ub);
    if (ua[n-1]) sa = sa - $signed(66'd1 << n);
    if (ub[n-1]) sb = sb - $signed(66'd1 << n);
    if (mode[0]) begin
      ex  = ua - ub;
      o.c = (ua >= ub);
      sr  = sa - sb;
    end else begin
      ex  = ua + ub;
      o.c = ex[n];
      sr  = sa + sb;
    end
    smax = $signed((66'd1 << (n - 1)) - 66'd1);
    smin = -smax - 66'sd1;
    o.v  = (sr > smax) || (sr < smin);
    ex   = ex & mask;
    if (n != w && ex[31]) ex = ex | ~mask;
    ex   = ex & wmask;
    o.r  = ex[63:0];
    o.z  = (o.r == 64'd0);
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'h0, $urandom};
      5:       return 64'h0000_0000_8000_0000;
      6:       return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic res_t cur();
    return {out_result, out_carry, out_ovf, out_zero};
  endfunction

  task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                          output int lat, output res_t got);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    out_ready = 1'b1;
    #4;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #4;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #4;
      lat++;
    end
    got = cur();
  endtask

  task automatic run_stream(input int n, input int pv, input int pr);
    res_t q[$];
    res_t hold_val;
    logic hold_v, pend;
    int   sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold_v = 1'b0; pend = 1'b0; hold_val = '0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < n && $urandom_range(99) < pv) begin
          in_valid = 1'b1;
          in_a     = rnd64();
          in_b     = rnd64();
          in_mode  = 2'($urandom_range(3));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(99) < pr);
      #4;
      if (hold_v) chk("stall_hold", {out_valid, cur()}, {1'b1, hold_val});
      hold_v   = out_valid && !out_ready;
      hold_val = cur();
      if (pr >= 100) chk("full_rate_in_ready", in_ready, 1);
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_mode, 64));
        sent++;
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_spurious: got %0h with no beat outstanding", cur());
        end else if (cur() !== q[0]) begin
          errors++;
          $display("FAIL stream_beat%0d: got %0h expected %0h", got, cur(), q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, n);
    chk("stream_sent", sent, n);
  endtask

  vec_t tbl[10];

  initial begin
    int   lat, seen;
    res_t got;
    beat_t bl[$];
    int   idx[2];
    int   stg[2];
    res_t m;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ADD_OP_ADD,  {64'h0, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{64'h8000_0000_0000_0000, 64'd1, ADD_OP_SUB,  {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0}};
    tbl[2] = '{64'h0000_0000_7FFF_FFFF, 64'd1, ADD_OP_ADDW, {64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{64'd5, 64'd5, ADD_OP_SUBW, {64'h0, 1'b1, 1'b0, 1'b1}};
    tbl[4] = '{64'd5, 64'd7, ADD_OP_SUB,  {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ADD_OP_ADD, {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}};
    tbl[6] = '{64'd0, 64'h8000_0000_0000_0000, ADD_OP_SUB, {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}};
    tbl[7] = '{64'h0000_0001_FFFF_FFFF, 64'd1, ADD_OP_ADDW, {64'h0, 1'b1, 1'b0, 1'b1}};
    tbl[8] = '{64'd0, 64'd1, ADD_OP_SUBW, {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0}};
    tbl[9] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, ADD_OP_ADD,
               {64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0}};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_mode = '0;

    repeat (3) @(negedge clk);
    #4;
    chk("reset_outputs", {out_valid, in_ready, cur()}, '0);
    chk("reset_small_valid", {s_ovld, s_irdy}, '0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("release_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      send_one(tbl[i].a, tbl[i].b, tbl[i].mode, lat, got);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_result", i), got, tbl[i].exp);
    end

    // Output held under backpressure; in_ready must drop while it waits.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 64'd100; in_b = 64'd58; in_mode = ADD_OP_SUB;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_result", {out_valid, cur()}, {1'b1, 64'd42, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    out_ready = 1'b1;

    run_stream(20, 100, 100);
    run_stream(100, 70, 50);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 64'd10; in_b = 64'd20; in_mode = ADD_OP_ADD;
    @(negedge clk);
    in_a = 64'd30;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #4;
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    #4;
    chk("midrst_outputs", {out_valid, cur()}, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #4;
    chk("midrst_release_rdy", in_ready, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #4;
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);
    send_one(64'h10, 64'h1, ADD_OP_SUB, lat, got);
    chk("postrst_latency", lat, 2);
    chk("postrst_result", got, {64'hF, 1'b1, 1'b0, 1'b0});

    // 32-bit instances: same beats into both, checked for exact latency and value.
    stg[0] = 1; stg[1] = 4; idx[0] = 0; idx[1] = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (cyc < 60) begin
        s_valid = 1'b1;
        s_a     = rnd64()[31:0];
        s_b     = rnd64()[31:0];
        s_mode  = 2'($urandom_range(3));
      end else begin
        s_valid = 1'b0;
      end
      #4;
      if (s_valid) begin
        chk("w32_in_ready", s_irdy, 2'b11);
        bl.push_back('{{32'h0, s_a}, {32'h0, s_b}, s_mode, cyc});
      end
      for (int i = 0; i < 2; i++) begin
        if (idx[i] < bl.size() && bl[idx[i]].cyc + stg[i] == cyc) begin
          m = model(bl[idx[i]].a, bl[idx[i]].b, bl[idx[i]].m, 32);
          chk($sformatf("w32_s%0d_beat%0d", stg[i], idx[i]),
              {s_ovld[i], s_res[i], s_c[i], s_v[i], s_z[i]}, {1'b1, m.r[31:0], m.c, m.v, m.z});
          idx[i]++;
        end else begin
          chk($sformatf("w32_s%0d_idle_c%0d", stg[i], cyc), s_ovld[i], 0);
        end
      end
    end
    chk("w32_s1_count", idx[0], 60);
    chk("w32_s4_count", idx[1], 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
